uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised, buffered successor to the UART transmitter. Accepts words over a valid/ready
//   handshake into an internal FIFO and serialises them on TXOut. Frames: start bit, DATA_WIDTH
//   data bits LSB first, optional parity, 1 or 2 stop bits. Programmable baud prescaler.
//   Sits between the system bus write path and the UART pin.
// PARAMETERS
//   DATA_WIDTH      8   data bits per frame (5..9)
//   FIFO_DEPTH      4   FIFO entries; power of two, >= 2
//   PRESCALE_WIDTH  16  width of Prescale input
// PORTS
//   CLK         in   1                      system clock, rising edge
//   RST         in   1                      asynchronous reset, active-high
//   ParallelData in  DATA_WIDTH             word to transmit
//   DataValid   in   1                      ParallelData valid
//   DataReady   out  1                      FIFO can accept; push = DataValid & DataReady
//   ParityEn    in   1                      1 = insert parity bit
//   ParityType  in   1                      0 = even, 1 = odd
//   StopBits2   in   1                      0 = one stop bit, 1 = two
//   Prescale    in   PRESCALE_WIDTH         bit period = Prescale+1 clocks
//   FifoLevel   out  $clog2(FIFO_DEPTH)+1   words held in FIFO (excludes word on the line)
//   Busy        out  1                      frame in progress (state != IDLE)
//   TXOut       out  1                      serial line, idle high, registered
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): TXOut=1, Busy=0, DataReady=1, FifoLevel=0,
//     FIFO pointers cleared, FSM=IDLE, bit/prescale counters 0. Partial frame is abandoned.
//   FIFO: DataReady = ~full. Push on edge when DataValid&DataReady. Pop only by FSM.
//     Push and pop same edge: level unchanged (legal when full: pop frees the slot, but
//     DataReady is already 0 that cycle, so no push). Pointers wrap modulo FIFO_DEPTH.
//   Config latch: ParityEn, ParityType, StopBits2, Prescale sampled at pop edge, held for
//     the frame; changes mid-frame affect only later frames.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE: TXOut=1. If FIFO non-empty: pop into shift reg, latch config -> START.
//     START: TXOut=0 for one bit period -> DATA.
//     DATA: TXOut=shift[0], shift right each bit period; after DATA_WIDTH bits ->
//       PARITY if ParityEn else STOP.
//     PARITY: TXOut = ^data ^ ParityType (even: total ones incl. parity even) -> STOP.
//     STOP: TXOut=1 for 1 or 2 bit periods. At end: if FIFO non-empty pop and -> START
//       (back-to-back, no idle bit, Busy stays 1), else -> IDLE.
//   Bit timing: prescale counter counts 0..Prescale; bit advances when count==Prescale.
//     Prescale=0 gives one clock per bit.
//   Latency: word pushed at edge N into empty FIFO while IDLE -> popped at edge N+1,
//     TXOut=0 and Busy=1 from edge N+1.
//   Frame length = (2 + DATA_WIDTH + ParityEn + StopBits2) * (Prescale+1) clocks.
//   FifoLevel updates on the edge of each push/pop.
// TESTING
//   1 Assert RST mid-frame -> TXOut=1, Busy=0, FifoLevel=0, DataReady=1 immediately.
//   2 Prescale=0, no parity, 1 stop, push 0xA5 -> TXOut 0,1,0,1,0,0,1,0,1,1 then idle 1;
//     Busy high 10 clocks.
//   3 ParityEn=1: 0x07 even -> parity 1; odd -> 0; 0x00 even -> 0.
//   4 Prescale=3, StopBits2=1, no parity, push 0x00 -> start+data low 36 clocks,
//     stop high 8 clocks, Busy high 44 clocks.
//   5 FIFO_DEPTH=4, DataValid held high from idle -> 5 words accepted, then DataReady=0,
//     FifoLevel=4; frames back-to-back with no idle bit; Busy high for 5 frames.
//   6 Change ParityEn/Prescale mid-frame -> current frame unchanged, next frame uses new.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input FIFO feeding a start/data/parity/stop serialiser
// with a programmable bit prescaler. Line configuration is captured per frame when a word is popped.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           ParallelData,
  input  logic                            DataValid,
  output logic                            DataReady,
  input  logic                            ParityEn,
  input  logic                            ParityType,
  input  logic                            StopBits2,
  input  logic [PRESCALE_WIDTH-1:0]       Prescale,
  output logic [$clog2(FIFO_DEPTH):0]     FifoLevel,
  output logic                            Busy,
  output logic                            TXOut
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                    state, state_nx;
  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]     head, shift, shift_nx;
  logic [PRESCALE_WIDTH-1:0] pcnt, pre_l;
  logic [BW-1:0]             bcnt;
  logic                      par_en_l, stop2_l, par_bit_l;
  logic                      push, pop, empty, tick, tx_nx, busy_nx;
  logic [LW-1:0]             level_nx;

  assign head  = mem[rd_ptr];
  assign push  = DataValid & DataReady;
  assign empty = (FifoLevel == '0);
  assign tick  = (pcnt == pre_l);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and pop decision
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nx = S_START;
          pop      = 1'b1;
        end
      end
      S_START:  if (tick) state_nx = S_DATA;
      S_DATA:   if (tick && bcnt == BW'(DATA_WIDTH - 1)) state_nx = par_en_l ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nx = S_STOP;
      S_STOP: begin
        // Back-to-back frames: pop straight into the next start bit
        if (tick && bcnt == BW'(stop2_l)) begin
          if (!empty) begin
            state_nx = S_START;
            pop      = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and shifter
  always_comb begin
    shift_nx = shift;
    tx_nx    = 1'b1;
    busy_nx  = (state_nx != S_IDLE);
    level_nx = FifoLevel + LW'(push) - LW'(pop);
    if (pop)                        shift_nx = head;
    else if (state == S_DATA && tick) shift_nx = shift >> 1;
    unique case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = par_bit_l;
      default:  tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= ParallelData;
  end

  // Datapath, FIFO bookkeeping and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FifoLevel <= '0;
      DataReady <= 1'b1;
      pcnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      pre_l     <= '0;
      par_en_l  <= 1'b0;
      stop2_l   <= 1'b0;
      par_bit_l <= 1'b0;
      TXOut     <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      FifoLevel <= level_nx;
      DataReady <= (level_nx != LW'(FIFO_DEPTH));
      if (state == S_IDLE || tick) pcnt <= '0;
      else                         pcnt <= pcnt + PRESCALE_WIDTH'(1);
      if (state_nx != state)                         bcnt <= '0;
      else if (tick && (state == S_DATA || state == S_STOP)) bcnt <= bcnt + BW'(1);
      if (pop) begin
        pre_l     <= Prescale;
        par_en_l  <= ParityEn;
        stop2_l   <= StopBits2;
        par_bit_l <= (^head) ^ ParityType;
      end
      shift <= shift_nx;
      TXOut <= tx_nx;
      Busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table of single-frame vectors with hand-computed
// serial bit strings, plus burst, mid-frame config change and mid-frame reset sequences.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] ParallelData;
  logic          DataValid;
  logic          DataReady;
  logic          ParityEn, ParityType, StopBits2;
  logic [PW-1:0] Prescale;
  logic [2:0]    FifoLevel;
  logic          Busy, TXOut;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [15:0] pre;
    string       bits;
    string       name;
  } vec_t;

  vec_t vecs[6];

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .ParallelData(ParallelData), .DataValid(DataValid),
    .DataReady(DataReady), .ParityEn(ParityEn), .ParityType(ParityType),
    .StopBits2(StopBits2), .Prescale(Prescale), .FifoLevel(FifoLevel),
    .Busy(Busy), .TXOut(TXOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic add_string(input string s, input int pre);
    for (int i = 0; i < s.len(); i++)
      for (int r = 0; r <= pre; r++) exp_q.push_back(s.getc(i) == 8'h31);
  endtask

  task automatic add_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input int pre);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back((^d) ^ pt);
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    foreach (b[i])
      for (int r = 0; r <= pre; r++) exp_q.push_back(b[i]);
  endtask

  task automatic push_word(input logic [7:0] d);
    ParallelData = d;
    DataValid    = 1'b1;
    @(negedge CLK);
    DataValid    = 1'b0;
  endtask

  // Waits for Busy, then compares TXOut per clock against exp_q and checks the busy length
  task automatic capture_check(input string name);
    int g, n, bad, first_bad;
    g = 0;
    while (!Busy && g < 50) begin
      @(negedge CLK);
      g++;
    end
    n = 0; bad = 0; first_bad = -1;
    while (Busy && n < exp_q.size() + 50) begin
      if (n >= exp_q.size() || TXOut !== exp_q[n]) begin
        if (first_bad < 0) first_bad = n;
        bad++;
      end
      n++;
      @(negedge CLK);
    end
    check({name, "_bit_errors(first_at ", $sformatf("%0d", first_bad), ")"}, bad, 0);
    check({name, "_busy_clocks"}, n, exp_q.size());
    check({name, "_idle_tx"}, TXOut, 1);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] w [5];
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd0, "0101001011",   "a5_plain"};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 16'd0, "01110000011",  "07_even"};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 16'd0, "01110000001",  "07_odd"};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 16'd0, "00000000001",  "00_even"};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'd3, "00000000011",  "00_pre3_stop2"};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'd1, "000111100111", "3c_pre1_odd_stop2"};
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    RST = 1'b1; DataValid = 1'b0; ParallelData = '0;
    ParityEn = 1'b0; ParityType = 1'b0; StopBits2 = 1'b0; Prescale = '0;
    repeat (2) @(negedge CLK);
    check("reset_tx", TXOut, 1);
    check("reset_busy", Busy, 0);
    check("reset_ready", DataReady, 1);
    check("reset_level", FifoLevel, 0);
    RST = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 6; v++) begin
      ParityEn = vecs[v].pe; ParityType = vecs[v].pt;
      StopBits2 = vecs[v].s2; Prescale = vecs[v].pre;
      push_word(vecs[v].data);
      check({vecs[v].name, "_level_after_push"}, FifoLevel, 1);
      add_string(vecs[v].bits, int'(vecs[v].pre));
      capture_check(vecs[v].name);
    end

    // Burst: DataValid held high until the FIFO fills
    ParityEn = 1'b0; ParityType = 1'b0; StopBits2 = 1'b0; Prescale = '0;
    foreach (w[i]) add_frame(w[i], 1'b0, 1'b0, 1'b0, 0);
    fork
      begin
        int n_acc;
        logic acc;
        int saw_full;
        n_acc = 0; saw_full = 0;
        ParallelData = w[0];
        DataValid = 1'b1;
        for (int c = 0; c < 40 && DataValid; c++) begin
          acc = DataReady;
          @(negedge CLK);
          if (acc) begin
            n_acc++;
            if (n_acc < 5) ParallelData = w[n_acc];
          end
          if (!DataReady) begin
            check("burst_accepted", n_acc, 5);
            check("burst_level_full", FifoLevel, 4);
            saw_full = 1;
            DataValid = 1'b0;
          end
        end
        DataValid = 1'b0;
        check("burst_reached_full", saw_full, 1);
      end
      capture_check("burst");
    join

    // Config changed mid-frame: first frame keeps old settings, second uses new ones
    add_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
    add_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1);
    fork
      begin
        push_word(8'h5A);
        push_word(8'h0F);
        repeat (2) @(negedge CLK);
        ParityEn = 1'b1;
        Prescale = 16'd1;
      end
      capture_check("midframe_cfg");
    join

    // Asynchronous reset in the middle of a data bit with a word still queued
    ParityEn = 1'b0; Prescale = 16'd3;
    push_word(8'h80);
    push_word(8'h42);
    repeat (5) @(negedge CLK);
    check("prereset_busy", Busy, 1);
    check("prereset_tx", TXOut, 0);
    check("prereset_level", FifoLevel, 1);
    #2 RST = 1'b1;
    #1;
    check("async_reset_tx", TXOut, 1);
    check("async_reset_busy", Busy, 0);
    check("async_reset_level", FifoLevel, 0);
    check("async_reset_ready", DataReady, 1);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("postreset_busy", Busy, 0);
    check("postreset_tx", TXOut, 1);
    check("postreset_level", FifoLevel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
